// File: rtl/secuenciador_melodia_pkg.sv
// Shared definitions for the melody player and the note ROM: FSM states,
// default bus widths and the board clock frequency.
package secuenciador_melodia_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int FREQ_W_DEF = 16;
    localparam int CLK_HZ     = 12_000_000;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SONANDO = 2'd1,
        PAUSA   = 2'd2,
        FIN     = 2'd3
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/secuenciador_melodia_tono.sv
// Square-wave generator: half-period counter plus toggle flop, cleared
// whenever habilitar is low or the requested half-period is zero (a rest).
import secuenciador_melodia_pkg::*;

module generador_tono #(
    parameter int FREQ_W = FREQ_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              habilitar,
    input  logic [FREQ_W-1:0] medio_periodo,
    output logic              salida
);

    logic [FREQ_W-1:0] cuenta_q, cuenta_d;
    logic              salida_q, salida_d;

    // Next half-period count and toggle level
    always_comb begin
        cuenta_d = cuenta_q;
        salida_d = salida_q;
        if (!habilitar || (medio_periodo == {FREQ_W{1'b0}})) begin
            cuenta_d = {FREQ_W{1'b0}};
            salida_d = 1'b0;
        end else if (cuenta_q >= (medio_periodo - FREQ_W'(1))) begin
            // >= keeps the wave bounded if a shorter period arrives mid-half-period
            cuenta_d = {FREQ_W{1'b0}};
            salida_d = ~salida_q;
        end else begin
            cuenta_d = cuenta_q + FREQ_W'(1);
            salida_d = salida_q;
        end
    end

    // Counter and output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta_q <= {FREQ_W{1'b0}};
            salida_q <= 1'b0;
        end else begin
            cuenta_q <= cuenta_d;
            salida_q <= salida_d;
        end
    end

    assign salida = salida_q;

endmodule

// File: rtl/secuenciador_melodia.sv
// Melody sequencer: steps the note ROM address, times each note and pause,
// and drives the buzzer. Define SECUENCIADOR_BUCLE_EN to loop the melody.
import secuenciador_melodia_pkg::*;

module secuenciador_melodia #(
    parameter int NUM_NOTAS    = 25,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FREQ_W       = FREQ_W_DEF,
    parameter int NOTA_CICLOS  = 6_000_000,
    parameter int PAUSA_CICLOS = 600_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              detener,
    input  logic [FREQ_W-1:0] frecuencia_de_nota,
    output logic [ADDR_W-1:0] direccion_nota,
    output logic              buzzer,
    output logic              reproduciendo,
    output logic              fin
);

    localparam int DUR_W = $clog2(max_int(NOTA_CICLOS, PAUSA_CICLOS));

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] dir_q, dir_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              rep_q, rep_d;
    logic              fin_q, fin_d;
    logic              fin_evento_s;
    logic              tono_en_s;

    // Next-state, address and duration counter
    always_comb begin
        estado_d     = estado_q;
        dir_d        = dir_q;
        dur_d        = dur_q;
        fin_evento_s = 1'b0;
        if (detener) begin
            estado_d = REPOSO;
            dir_d    = {ADDR_W{1'b0}};
            dur_d    = {DUR_W{1'b0}};
        end else begin
            case (estado_q)
                REPOSO: begin
                    dir_d = {ADDR_W{1'b0}};
                    dur_d = {DUR_W{1'b0}};
                    if (iniciar) begin
                        estado_d = SONANDO;
                    end else begin
                        estado_d = REPOSO;
                    end
                end
                SONANDO: begin
                    if (dur_q == DUR_W'(NOTA_CICLOS - 1)) begin
                        estado_d = PAUSA;
                        dur_d    = {DUR_W{1'b0}};
                    end else begin
                        dur_d = dur_q + DUR_W'(1);
                    end
                end
                PAUSA: begin
                    if (dur_q == DUR_W'(PAUSA_CICLOS - 1)) begin
                        dur_d = {DUR_W{1'b0}};
                        if (dir_q < ADDR_W'(NUM_NOTAS - 1)) begin
                            dir_d    = dir_q + ADDR_W'(1);
                            estado_d = SONANDO;
                        end else begin
`ifdef SECUENCIADOR_BUCLE_EN
                            dir_d        = {ADDR_W{1'b0}};
                            estado_d     = SONANDO;
                            fin_evento_s = 1'b1;
`else
                            estado_d = FIN;
`endif
                        end
                    end else begin
                        dur_d = dur_q + DUR_W'(1);
                    end
                end
                FIN: begin
                    dir_d    = {ADDR_W{1'b0}};
                    dur_d    = {DUR_W{1'b0}};
                    estado_d = REPOSO;
                end
                default: begin
                    dir_d    = {ADDR_W{1'b0}};
                    dur_d    = {DUR_W{1'b0}};
                    estado_d = REPOSO;
                end
            endcase
        end
    end

    // Status outputs follow the state being entered so they stay registered
    always_comb begin
        rep_d     = (estado_d == SONANDO) || (estado_d == PAUSA);
        fin_d     = fin_evento_s || (estado_d == FIN);
        // Dropping enable on the exit edge zeroes the buzzer as SONANDO ends
        tono_en_s = (estado_q == SONANDO) && (estado_d == SONANDO);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= REPOSO;
            dir_q    <= {ADDR_W{1'b0}};
            dur_q    <= {DUR_W{1'b0}};
            rep_q    <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            dir_q    <= dir_d;
            dur_q    <= dur_d;
            rep_q    <= rep_d;
            fin_q    <= fin_d;
        end
    end

    generador_tono #(
        .FREQ_W(FREQ_W)
    ) u_tono (
        .clk          (clk),
        .reset        (reset),
        .habilitar    (tono_en_s),
        .medio_periodo(frecuencia_de_nota),
        .salida       (buzzer)
    );

    assign direccion_nota = dir_q;
    assign reproduciendo  = rep_q;
    assign fin            = fin_q;

endmodule

// File: tb/tb_secuenciador_melodia.sv
// Bench for secuenciador_melodia with a behavioural timeline model; honours
// SECUENCIADOR_BUCLE_EN the same way as the RTL.
module tb_secuenciador_melodia;

    localparam int NN   = 3;
    localparam int NC   = 100;
    localparam int PC   = 10;
    localparam int SLOT = NC + PC;
    localparam int PASS = NN * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic        iniciar;
    logic        detener;
    logic [15:0] frecuencia_de_nota;
    logic [4:0]  direccion_nota;
    logic        buzzer;
    logic        reproduciendo;
    logic        fin;

    logic [15:0] rom [32];

    int vectors = 0;
    int miscompares = 0;
    int fin_seen = 0;
    int fin_before;

    // Model: 0 idle, 1 playing (t = clocks since pass start), 2 end cycle
    int m_mode = 0;
    int m_t = 0;
    bit m_fin_loop = 1'b0;
    int ea, eb, er, ef, n, r;

    always #5 clk = ~clk;

    assign frecuencia_de_nota = rom[direccion_nota];

    secuenciador_melodia #(
        .NUM_NOTAS   (NN),
        .ADDR_W      (5),
        .FREQ_W      (16),
        .NOTA_CICLOS (NC),
        .PAUSA_CICLOS(PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .iniciar           (iniciar),
        .detener           (detener),
        .frecuencia_de_nota(frecuencia_de_nota),
        .direccion_nota    (direccion_nota),
        .buzzer            (buzzer),
        .reproduciendo     (reproduciendo),
        .fin               (fin)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first SONANDO cycle
    task automatic start();
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
    endtask

    task automatic stop_pulse();
        detener = 1'b1;
        @(negedge clk);
        detener = 1'b0;
    endtask

    // Behavioural timeline of the player
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode     <= 0;
            m_t        <= 0;
            m_fin_loop <= 1'b0;
        end else begin
            m_fin_loop <= 1'b0;
            if (detener) begin
                m_mode <= 0;
            end else if (m_mode == 0) begin
                if (iniciar) begin
                    m_mode <= 1;
                    m_t    <= 0;
                end
            end else if (m_mode == 1) begin
                if (m_t == PASS - 1) begin
`ifdef SECUENCIADOR_BUCLE_EN
                    m_t        <= 0;
                    m_fin_loop <= 1'b1;
`else
                    m_mode <= 2;
`endif
                end else begin
                    m_t <= m_t + 1;
                end
            end else begin
                m_mode <= 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            ea = 0; eb = 0; er = 0; ef = 0;
            if (m_mode == 1) begin
                n  = m_t / SLOT;
                r  = m_t % SLOT;
                ea = n;
                er = 1;
                ef = m_fin_loop ? 1 : 0;
                if (r < NC && rom[n] != 16'd0) eb = (r / int'(rom[n])) % 2;
            end else if (m_mode == 2) begin
                ea = NN - 1;
                ef = 1;
            end
            chk("direccion_nota", int'(direccion_nota), ea);
            chk("buzzer", int'(buzzer), eb);
            chk("reproduciendo", int'(reproduciendo), er);
            chk("fin", int'(fin), ef);
            if (fin) fin_seen++;
        end
    end

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        detener = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 16'd0;
        rom[0] = 16'd4;
        rom[1] = 16'd6;
        rom[2] = 16'd0;

        tick(3);
        chk("reset_addr", int'(direccion_nota), 0);
        chk("reset_buzzer", int'(buzzer), 0);
        chk("reset_rep", int'(reproduciendo), 0);
        chk("reset_fin", int'(fin), 0);
        #3 reset = 1'b0;
        tick(6);

        // Full pass with hand-computed checkpoints
        start();
        chk("c0_rep", int'(reproduciendo), 1);
        chk("c0_addr", int'(direccion_nota), 0);
        tick(5);
        chk("c5_buzzer", int'(buzzer), 1);
        tick(3);
        chk("c8_buzzer", int'(buzzer), 0);
        tick(92);
        chk("c100_pause_buzzer", int'(buzzer), 0);
        chk("c100_addr", int'(direccion_nota), 0);
        tick(10);
        chk("c110_addr", int'(direccion_nota), 1);
        tick(6);
        chk("c116_buzzer", int'(buzzer), 1);
        tick(134);
        chk("c250_addr", int'(direccion_nota), 2);
        chk("c250_rest_buzzer", int'(buzzer), 0);
        tick(79);
        chk("c329_fin", int'(fin), 0);
        tick(1);
        chk("c330_fin", int'(fin), 1);
`ifdef SECUENCIADOR_BUCLE_EN
        chk("c330_rep", int'(reproduciendo), 1);
        chk("c330_addr", int'(direccion_nota), 0);
`else
        chk("c330_rep", int'(reproduciendo), 0);
        chk("c330_addr", int'(direccion_nota), 2);
`endif
        tick(1);
        chk("c331_fin", int'(fin), 0);
        chk("c331_addr", int'(direccion_nota), 0);
        stop_pulse();
        tick(4);

        // Asynchronous reset in the middle of a note
        start();
        tick(20);
        chk("c20_buzzer", int'(buzzer), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_buzzer", int'(buzzer), 0);
        chk("async_addr", int'(direccion_nota), 0);
        chk("async_rep", int'(reproduciendo), 0);
        @(negedge clk);
        #3 reset = 1'b0;
        tick(8);

        // Stop at clock 50 of note 1
        fin_before = fin_seen;
        start();
        tick(SLOT + 50);
        stop_pulse();
        chk("stop_rep", int'(reproduciendo), 0);
        chk("stop_buzzer", int'(buzzer), 0);
        chk("stop_addr", int'(direccion_nota), 0);
        tick(PASS);
        chk("stop_no_fin", fin_seen, fin_before);

        // Simultaneous start and stop while idle
        iniciar = 1'b1;
        detener = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        detener = 1'b0;
        chk("both_rep", int'(reproduciendo), 0);
        tick(3);

        // Start re-pulsed mid-note must not restart
        start();
        tick(30);
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        tick(SLOT - 30);
        chk("repulse_addr", int'(direccion_nota), 1);
        tick(PASS);
        stop_pulse();
        tick(3);

        // Randomized controls and ROM contents
        for (int c = 0; c < 5000; c++) begin
            if (m_mode == 0 && ($urandom % 8) == 0) begin
                for (int j = 0; j < NN; j++) rom[j] = 16'($urandom_range(0, 12));
            end
            iniciar = (($urandom % 25) == 0);
            detener = (($urandom % 500) == 0);
            @(negedge clk);
        end
        iniciar = 1'b0;
        detener = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
